// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants for the 4x3 keypad controller front end.
//   KEY_NONE  - code reported when no key bit is set (also bit 15's index)
//   KEY_STAR  - index of the '*' key
//   KEY_HASH  - index of the '#' key
//   KEY_BUSY  - code the parent reserves for "busy/acknowledged"
//   DEF_CLK_HZ / DEF_OUT_HZ - default board clock and row-scan rates
package keypad_pkg;

  localparam logic [3:0] KEY_NONE = 4'hF;
  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;
  localparam logic [3:0] KEY_BUSY = 4'd13;

  localparam int DEF_CLK_HZ = 100_000_000;
  localparam int DEF_OUT_HZ = 100;

endpackage

// File: rtl/priority_encoder_164.sv
// priority_encoder_164: 16-to-4 priority encoder, highest set index wins.
// Purely combinational; holds no state.
//   i     [15:0] in  - request vector
//   out   [3:0]  out - index of highest set bit, KEY_NONE when i == 0
//   valid        out - any bit of i set
module priority_encoder_164
  import keypad_pkg::*;
(
  input  logic [15:0] i,
  output logic [3:0]  out,
  output logic        valid
);

  // Ascending scan so the last (highest) set bit overwrites lower ones.
  // Bit 15 and the empty case both give 4'hF; valid tells them apart.
  always_comb begin
    out = KEY_NONE;
    for (int n = 0; n < 16; n++) begin
      if (i[n]) out = 4'(n);
    end
  end

  assign valid = |i;

endmodule

// File: rtl/keypad_clock_div.sv
// keypad_clock_div: row-scan clock divider plus key-hit encoder.
//   CLK_HZ, OUT_HZ - input clock and scan clock rates; CLK_HZ/(2*OUT_HZ)
//                    must be an integer >= 1
//   clk        in  - system clock, rising edge
//   reset      in  - synchronous, active-high
//   keys[15:0] in  - key-hit vector, bit n = key n pressed
//   clk_out    out - 50% duty square wave at OUT_HZ
//   tick       out - one-clk pulse aligned with each clk_out rising edge
//   key_code   out - index of highest set bit of keys (4'hF when none)
//   key_valid  out - any key bit set
module keypad_clock_div
  import keypad_pkg::*;
#(
  parameter int CLK_HZ = DEF_CLK_HZ,
  parameter int OUT_HZ = DEF_OUT_HZ
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] keys,
  output logic        clk_out,
  output logic        tick,
  output logic [3:0]  key_code,
  output logic        key_valid
);

  localparam int HALF = CLK_HZ / (2 * OUT_HZ);
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  logic [CW-1:0] count;
  logic          wrap;

  assign wrap = (count == LAST);

  // Reset is checked first so a reset landing on a wrap cycle suppresses
  // both the toggle and the tick. tick is set on the same edge that drives
  // clk_out high, so the two rise together.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (wrap) begin
      count   <= '0;
      clk_out <= ~clk_out;
      tick    <= ~clk_out;
    end else begin
      count   <= count + 1'b1;
      tick    <= 1'b0;
    end
  end

  priority_encoder_164 u_enc (
    .i     (keys),
    .out   (key_code),
    .valid (key_valid)
  );

endmodule

// File: tb/tb_keypad_clock_div.sv
module tb_keypad_clock_div;

  logic        clk = 1'b0;
  logic        r5 = 1'b1, r1 = 1'b1;
  logic [15:0] keys = '0;
  logic        co5, tk5, kv5, co1, tk1, kv1;
  logic [3:0]  kc5, kc1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // HALF = 5
  keypad_clock_div #(.CLK_HZ(1000), .OUT_HZ(100)) u5 (
    .clk(clk), .reset(r5), .keys(keys),
    .clk_out(co5), .tick(tk5), .key_code(kc5), .key_valid(kv5)
  );

  // HALF = 1
  keypad_clock_div #(.CLK_HZ(200), .OUT_HZ(100)) u1 (
    .clk(clk), .reset(r1), .keys(keys),
    .clk_out(co1), .tick(tk1), .key_code(kc1), .key_valid(kv1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_div5(input string tag, input logic c, input logic t);
    chk({tag, " clk_out"}, {31'd0, co5}, {31'd0, c});
    chk({tag, " tick"},    {31'd0, tk5}, {31'd0, t});
  endtask

  initial begin
    // reset held for 3 cycles
    repeat (3) step();
    chk_div5("reset5", 1'b0, 1'b0);
    chk("reset1 clk_out", {31'd0, co1}, 32'd0);
    chk("reset1 tick",    {31'd0, tk1}, 32'd0);

    // period/duty: edge k after release -> high when k%10 in 5..9, tick at 5
    r5 = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      step();
      chk_div5($sformatf("div5 k=%0d", k), (k % 10) >= 5, (k % 10) == 5);
    end

    // into high phase: k=105 rise (count 0), k=108 count 3
    for (int k = 101; k <= 108; k++) step();
    chk_div5("pre-reset high", 1'b1, 1'b0);
    r5 = 1'b1;
    step();
    chk_div5("mid reset", 1'b0, 1'b0);
    r5 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk_div5($sformatf("after mid reset k=%0d", k), k == 5, k == 5);
    end

    // reset on a wrap cycle: run to count 4 of low phase (k=14 since last rise)
    for (int k = 6; k <= 14; k++) step();
    chk_div5("pre-wrap low", 1'b0, 1'b0);
    r5 = 1'b1;
    step();
    chk_div5("wrap reset", 1'b0, 1'b0);
    r5 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk_div5($sformatf("after wrap reset k=%0d", k), k == 5, k == 5);
    end

    // HALF = 1: clk_out toggles every edge, tick on every rising one
    r1 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("half1 clk_out k=%0d", k), {31'd0, co1}, {31'd0, k[0]});
      chk($sformatf("half1 tick k=%0d", k),    {31'd0, tk1}, {31'd0, k[0]});
    end

    // encoder single-hot sweep
    for (int b = 0; b < 16; b++) begin
      keys = 16'd1 << b;
      #1;
      chk($sformatf("onehot code b=%0d", b), {28'd0, kc5}, b);
      chk($sformatf("onehot valid b=%0d", b), {31'd0, kv5}, 32'd1);
    end

    keys = 16'h0C06; #1;
    chk("prio 0C06 code", {28'd0, kc5}, 32'd11);
    chk("prio 0C06 valid", {31'd0, kv5}, 32'd1);
    keys = 16'h0003; #1;
    chk("prio 0003 code", {28'd0, kc5}, 32'd1);
    keys = 16'h0081; #1;
    chk("prio 0081 code", {28'd0, kc1}, 32'd7);
    keys = 16'h0000; #1;
    chk("empty code", {28'd0, kc5}, 32'hF);
    chk("empty valid", {31'd0, kv5}, 32'd0);
    keys = 16'h8000; #1;
    chk("bit15 code", {28'd0, kc5}, 32'hF);
    chk("bit15 valid", {31'd0, kv5}, 32'd1);

    // encoder independent of reset
    r5 = 1'b1; r1 = 1'b1;
    step();
    keys = 16'h0400; #1;
    chk("rst enc 0400 code", {28'd0, kc5}, 32'd10);
    chk("rst enc 0400 valid", {31'd0, kv5}, 32'd1);
    keys = 16'h0000; #1;
    chk("rst enc 0 code", {28'd0, kc5}, 32'hF);
    chk("rst enc 0 valid", {31'd0, kv5}, 32'd0);
    keys = 16'h0A20; #1;
    chk("rst enc 0A20 code", {28'd0, kc1}, 32'd11);
    step();
    chk_div5("held reset", 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_clock_div.md
# keypad_clock_div

Scan-timing and key-encode front end for the 4x3 matrix keypad controller. It divides the system clock down to the 100 Hz row-scan rate as a square wave plus a one-cycle enable strobe. It also priority-encodes the 16-bit key-hit vector into a 4-bit key code. It sits between the board clock and the keypad row-scan/debounce logic, which consumes `clk_out`/`tick`, `key_code` and `key_valid`.

## Interface
- `CLK_HZ`, default 100_000_000: input clock frequency in Hz.
- `OUT_HZ`, default 100: scan clock frequency in Hz. The ratio CLK_HZ/(2*OUT_HZ) must be an integer ≥ 1.
- `clk`  in  1  system clock. All state is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `keys`  in  16  key-hit vector. Bit n set means key n is pressed. Bits 12–15 are unused by the 4x3 pad and are tied 0 by the parent.
- `clk_out`  out  1  50 % duty square wave at OUT_HZ.
- `tick`  out  1  one-`clk` pulse coincident with each rising edge of `clk_out`.
- `key_code`  out  4  index of the highest-numbered set bit of `keys`.
- `key_valid`  out  1  high when any bit of `keys` is set.

## Operation
- **Divider constant:** HALF = CLK_HZ/(2*OUT_HZ), computed at elaboration. The counter width is clog2(HALF), with a minimum of 1.
- **Counter:** the counter increments every `clk`. When count == HALF-1:
  - count wraps to 0;
  - `clk_out` toggles;
  - `tick` is 1 for that cycle only if `clk_out` is toggling 0→1.
- **Tick register:** `tick` is registered. It is high in the cycle after the edge that sets `clk_out`=1, i.e. aligned with `clk_out`'s rising edge.
- **Reset values:** count=0, `clk_out`=0, `tick`=0. Reset applied mid-period discards the partial period. The first rising `clk_out` occurs HALF cycles after reset is released.
- **Encoder:** purely combinational, with no clock or reset dependence.
  - Highest set index wins. Example: `keys`=16'h0081 gives `key_code`=7.
  - `keys`==0 gives `key_code`=4'hF and `key_valid`=0.
  - `keys`=16'h8000 gives `key_code`=4'hF and `key_valid`=1. `key_valid` disambiguates the two cases.
- **Key index map:** index 0 is digit 0, 1–9 are digits, 10 is `*`, 11 is `#`. Code 13 is reserved by the parent for "busy/acknowledged" and is never produced from bits 0–11.

## Timing
- **Divider period:** period 2*HALF `clk` cycles and exact 50 % duty.
  - Default HALF is 500_000, giving a 1_000_000-cycle period.
  - `tick` is high 1 cycle in every 2*HALF.
- **HALF = 1:** `clk_out` toggles every cycle and `tick` fires every second cycle.
- **Encoder timing:** zero-latency combinational path from `keys` to `key_code`/`key_valid`. The encoder holds no state, so reset does not affect it.
- **Simultaneous events:** reset asserted in a wrap cycle wins; no toggle and no tick occur.

## Structure
- Shared package `keypad_pkg`:
  - `KEY_NONE` = 4'hF;
  - `KEY_STAR` = 4'd10;
  - `KEY_HASH` = 4'd11;
  - `KEY_BUSY` = 4'd13;
  - the default `CLK_HZ`/`OUT_HZ`.
- Sub-module `priority_encoder_164`: ports `i[15:0]`, `out[3:0]`, `valid`. It is instantiated once, and the divider logic lives in the top.

## Test plan
- **Period and duty:** CLK_HZ=1000, OUT_HZ=100 (HALF=5), reset 3 cycles then release. Required response:
  - `clk_out` rises 5 cycles after release;
  - period 10 cycles, high 5, low 5;
  - `tick` high exactly 1 cycle per period, on the rising edge;
  - check over 10 periods.
- **Reset mid-operation:** same setup, assert reset at count 3 of a high phase. Required response: `clk_out`=0, `tick`=0 the next cycle, and the next rise 5 cycles after release.
- **HALF=1 boundary:** CLK_HZ=200, OUT_HZ=100. Required response: `clk_out` toggles every cycle and `tick` pulses every 2 cycles.
- **Encoder single-hot sweep:** walk one set bit through 0..15. Required response: `key_code` equals the bit index and `key_valid`=1 for each position.
- **Encoder priority and empty cases:**
  - `keys`=16'h0C06 gives code 11;
  - `keys`=16'h0003 gives code 1;
  - `keys`=0 gives code 4'hF with `key_valid`=0;
  - `keys`=16'h8000 gives code 4'hF with `key_valid`=1.
- **Encoder independence:** toggle `keys` while reset is held high. Required response: `key_code` still tracks `keys` combinationally.
